cache_response_field_packer: RTL and testbench

- Parametrised successor to the fixed four-field response/packet path.
- Gathers single-word cache responses (one rdata per beat) into one multi-field memory packet, NUM_FIELDS words wide.
- Closes a packet early on sequence DONE/BREAK, on a change of seq_id, or on an idle timeout.
- Sits between the cache response port and the engine/lane packet input, so engines receive packed multi-field packets.

---
 rtl/cache_response_field_packer.sv | 175 +++++++++++++++++
 tb/tb_cache_response_field_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_response_field_packer.sv
// Gathers single-word cache response beats into NUM_FIELDS-wide packets with one
// output register; packets close on a full packet, DONE/BREAK, seq_id change or idle timeout.
module cache_response_field_packer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_FIELDS    = 4,
  parameter int unsigned META_W        = 64,
  parameter int unsigned SEQ_ID_W      = 8,
  parameter int unsigned FLUSH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = $clog2(NUM_FIELDS + 1)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         resp_in_valid,
  output logic                         resp_in_ready,
  input  logic [DATA_W-1:0]            resp_in_data,
  input  logic [META_W-1:0]            resp_in_meta,
  input  logic [SEQ_ID_W-1:0]          resp_in_seq_id,
  input  logic [3:0]                   resp_in_seq_state,
  output logic                         pkt_out_valid,
  input  logic                         pkt_out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] pkt_out_data,
  output logic [META_W-1:0]            pkt_out_meta,
  output logic [SEQ_ID_W-1:0]          pkt_out_seq_id,
  output logic [3:0]                   pkt_out_seq_state,
  output logic [CNT_W-1:0]             pkt_out_count,
  output logic [15:0]                  drop_count
);

  // Timer only needs to reach FLUSH_TIMEOUT-1: the expiring idle cycle itself is the last one.
  localparam int unsigned TmrW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TmrW-1:0] TmrLast =
      (FLUSH_TIMEOUT > 0) ? TmrW'(FLUSH_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NUM_FIELDS - 1);

  localparam logic [3:0] StInvalid = 4'b0001;
  localparam logic [3:0] StRunning = 4'b0010;
  localparam logic [3:0] StDone    = 4'b0100;
  localparam logic [3:0] StBreak   = 4'b1000;

  // Accumulator: the last field never needs storage, it goes straight to the output register.
  logic [DATA_W-1:0]   acc_data_q [NUM_FIELDS-1];
  logic [CNT_W-1:0]    cnt_q;
  logic [META_W-1:0]   acc_meta_q;
  logic [SEQ_ID_W-1:0] acc_seq_id_q;
  logic [TmrW-1:0]     timer_q;

  logic                         out_valid_q;
  logic [NUM_FIELDS*DATA_W-1:0] out_data_q;
  logic [META_W-1:0]            out_meta_q;
  logic [SEQ_ID_W-1:0]          out_seq_id_q;
  logic [3:0]                   out_state_q;
  logic [CNT_W-1:0]             out_count_q;
  logic [15:0]                  drop_q;

  logic st_onehot, is_invalid, is_done, is_break;
  logic cnt_nz, mismatch, closes, out_free, accept;
  logic take_drop, take_beat, take_close, take_append, store_field;
  logic mis_flush, expired, tmo_flush, load;

  logic [NUM_FIELDS*DATA_W-1:0] pkt_data;
  logic [CNT_W-1:0]             pkt_count;
  logic [3:0]                   pkt_state;
  logic [META_W-1:0]            pkt_meta;
  logic [SEQ_ID_W-1:0]          pkt_seq_id;

  always_comb begin
    st_onehot  = (resp_in_seq_state == StInvalid) || (resp_in_seq_state == StRunning) ||
                 (resp_in_seq_state == StDone)    || (resp_in_seq_state == StBreak);
    is_invalid = !st_onehot || (resp_in_seq_state == StInvalid);
    is_done    = (resp_in_seq_state == StDone);
    is_break   = (resp_in_seq_state == StBreak);

    cnt_nz   = (cnt_q != '0);
    mismatch = cnt_nz && (resp_in_seq_id != acc_seq_id_q);
    closes   = (cnt_q == CntLast) || is_done || is_break;
    out_free = !out_valid_q || pkt_out_ready;

    resp_in_ready = !mismatch && (out_free || !closes);
    accept        = resp_in_valid && resp_in_ready;
    take_drop     = accept && is_invalid;
    take_beat     = accept && !is_invalid;
    take_close    = take_beat && closes;
    take_append   = take_beat && !closes;
    store_field   = take_close && !is_break;

    // A stalled mismatching beat hands the partial packet out to make room for itself.
    mis_flush = resp_in_valid && mismatch && out_free;
    expired   = (FLUSH_TIMEOUT != 0) && cnt_nz && !take_beat && (timer_q == TmrLast);
    tmo_flush = expired && out_free && !mis_flush;
    load      = take_close || mis_flush || tmo_flush;
  end

  always_comb begin
    pkt_data = '0;
    for (int i = 0; i < int'(NUM_FIELDS) - 1; i++) begin
      if (CNT_W'(i) < cnt_q) pkt_data[i*DATA_W +: DATA_W] = acc_data_q[i];
    end
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if (store_field && (CNT_W'(i) == cnt_q)) pkt_data[i*DATA_W +: DATA_W] = resp_in_data;
    end

    pkt_count = store_field ? cnt_q + CNT_W'(1) : cnt_q;

    pkt_state = StRunning;
    if (take_close && is_done)  pkt_state = StDone;
    if (take_close && is_break) pkt_state = StBreak;

    // A packet that starts with its closing beat takes meta and id from that beat.
    pkt_meta   = cnt_nz ? acc_meta_q   : resp_in_meta;
    pkt_seq_id = cnt_nz ? acc_seq_id_q : resp_in_seq_id;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < int'(NUM_FIELDS) - 1; i++) acc_data_q[i] <= '0;
      cnt_q        <= '0;
      acc_meta_q   <= '0;
      acc_seq_id_q <= '0;
      timer_q      <= '0;
    end else begin
      if (take_append) begin
        for (int i = 0; i < int'(NUM_FIELDS) - 1; i++) begin
          if (CNT_W'(i) == cnt_q) acc_data_q[i] <= resp_in_data;
        end
        if (!cnt_nz) begin
          acc_meta_q   <= resp_in_meta;
          acc_seq_id_q <= resp_in_seq_id;
        end
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (load) begin
        cnt_q <= '0;
      end

      if (!cnt_nz || take_beat || load) begin
        timer_q <= '0;
      end else if (timer_q != TmrLast) begin
        timer_q <= timer_q + TmrW'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_meta_q   <= '0;
      out_seq_id_q <= '0;
      out_state_q  <= '0;
      out_count_q  <= '0;
      drop_q       <= '0;
    end else begin
      if (load) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= pkt_data;
        out_meta_q   <= pkt_meta;
        out_seq_id_q <= pkt_seq_id;
        out_state_q  <= pkt_state;
        out_count_q  <= pkt_count;
      end else if (pkt_out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (take_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign pkt_out_valid     = out_valid_q;
  assign pkt_out_data      = out_data_q;
  assign pkt_out_meta      = out_meta_q;
  assign pkt_out_seq_id    = out_seq_id_q;
  assign pkt_out_seq_state = out_state_q;
  assign pkt_out_count     = out_count_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_cache_response_field_packer.sv
// Bench for cache_response_field_packer: vector table plus handshake corner sequences,
// with expected packets queued at drive time and checked when the DUT hands them out.
module tb_cache_response_field_packer;

  localparam int DW = 32;
  localparam int NF = 4;
  localparam int MW = 64;
  localparam int SW = 8;
  localparam int CW = 3;

  localparam logic [3:0] RUN = 4'b0010;
  localparam logic [3:0] DON = 4'b0100;
  localparam logic [3:0] BRK = 4'b1000;
  localparam logic [3:0] INV = 4'b0001;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic          resp_in_valid = 1'b0;
  logic [DW-1:0] resp_in_data = '0;
  logic [MW-1:0] resp_in_meta = '0;
  logic [SW-1:0] resp_in_seq_id = '0;
  logic [3:0]    resp_in_seq_state = '0;
  logic          pkt_out_ready = 1'b1;

  logic             resp_in_ready, pkt_out_valid;
  logic [NF*DW-1:0] pkt_out_data;
  logic [MW-1:0]    pkt_out_meta;
  logic [SW-1:0]    pkt_out_seq_id;
  logic [3:0]       pkt_out_seq_state;
  logic [CW-1:0]    pkt_out_count;
  logic [15:0]      drop_count;

  logic             nt_ready, nt_valid;
  logic [NF*DW-1:0] nt_data;
  logic [MW-1:0]    nt_meta;
  logic [SW-1:0]    nt_seq_id;
  logic [3:0]       nt_state;
  logic [CW-1:0]    nt_count;
  logic [15:0]      nt_drop;

  cache_response_field_packer #(
    .DATA_W(DW), .NUM_FIELDS(NF), .META_W(MW), .SEQ_ID_W(SW), .FLUSH_TIMEOUT(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .resp_in_valid(resp_in_valid), .resp_in_ready(resp_in_ready),
    .resp_in_data(resp_in_data), .resp_in_meta(resp_in_meta),
    .resp_in_seq_id(resp_in_seq_id), .resp_in_seq_state(resp_in_seq_state),
    .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .pkt_out_data(pkt_out_data), .pkt_out_meta(pkt_out_meta),
    .pkt_out_seq_id(pkt_out_seq_id), .pkt_out_seq_state(pkt_out_seq_state),
    .pkt_out_count(pkt_out_count), .drop_count(drop_count)
  );

  // Same stimulus, flush disabled; only its valid is observed.
  cache_response_field_packer #(
    .DATA_W(DW), .NUM_FIELDS(NF), .META_W(MW), .SEQ_ID_W(SW), .FLUSH_TIMEOUT(0)
  ) dut_nt (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .resp_in_valid(resp_in_valid), .resp_in_ready(nt_ready),
    .resp_in_data(resp_in_data), .resp_in_meta(resp_in_meta),
    .resp_in_seq_id(resp_in_seq_id), .resp_in_seq_state(resp_in_seq_state),
    .pkt_out_valid(nt_valid), .pkt_out_ready(pkt_out_ready),
    .pkt_out_data(nt_data), .pkt_out_meta(nt_meta),
    .pkt_out_seq_id(nt_seq_id), .pkt_out_seq_state(nt_state),
    .pkt_out_count(nt_count), .drop_count(nt_drop)
  );

  typedef struct {
    logic [NF*DW-1:0] data;
    logic [MW-1:0]    meta;
    logic [SW-1:0]    id;
    logic [3:0]       st;
    logic [CW-1:0]    cnt;
  } pkt_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] id;
    logic [3:0]    st;
    logic [MW-1:0] meta;
    bit            has_pkt;
    pkt_t          pkt;
  } vec_t;

  pkt_t exp_q[$];
  pkt_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [NF*DW-1:0] act,
                       input logic [NF*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mkp(input logic [NF*DW-1:0] d, input logic [MW-1:0] m,
                               input logic [SW-1:0] id, input logic [3:0] st,
                               input logic [CW-1:0] c);
    pkt_t p;
    p.data = d; p.meta = m; p.id = id; p.st = st; p.cnt = c;
    return p;
  endfunction

  function automatic vec_t mkv(input logic [DW-1:0] d, input logic [SW-1:0] id,
                               input logic [3:0] st, input logic [MW-1:0] m,
                               input bit has, input pkt_t p);
    vec_t v;
    v.data = d; v.id = id; v.st = st; v.meta = m; v.has_pkt = has; v.pkt = p;
    return v;
  endfunction

  // Scoreboard: compare each handed-off packet against the oldest expectation.
  always @(negedge ap_clk) begin
    if (ap_rst_n && pkt_out_valid && pkt_out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_packet: got count %0d id %0h data %0h, expected none",
                 pkt_out_count, pkt_out_seq_id, pkt_out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pkt_data",  pkt_out_data,      mon_e.data);
        check("pkt_meta",  pkt_out_meta,      mon_e.meta);
        check("pkt_id",    pkt_out_seq_id,    mon_e.id);
        check("pkt_state", pkt_out_seq_state, mon_e.st);
        check("pkt_count", pkt_out_count,     mon_e.cnt);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] id, input logic [3:0] st,
                      input logic [MW-1:0] m, output int stalls);
    resp_in_data = d; resp_in_seq_id = id; resp_in_seq_state = st; resp_in_meta = m;
    resp_in_valid = 1'b1;
    stalls = 0;
    @(negedge ap_clk);
    while (!resp_in_ready && stalls < 50) begin
      stalls++;
      @(negedge ap_clk);
    end
    if (!resp_in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles, expected acceptance", stalls);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    resp_in_valid = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, pkt_out_valid, 0);
    check({tag, "_data"},  pkt_out_data, 0);
    check({tag, "_count"}, pkt_out_count, 0);
    check({tag, "_state"}, pkt_out_seq_state, 0);
    check({tag, "_meta_id"}, {pkt_out_meta, pkt_out_seq_id}, 0);
    check({tag, "_drop"},  drop_count, 0);
  endtask

  vec_t vt[14];
  pkt_t np;

  initial begin
    int s, k, bad, nt_bad;
    np = mkp('0, '0, '0, '0, '0);
    vt[0]  = mkv(32'h11, 8'd5, RUN, 64'h1000_0000_0000_00A1, 0, np);
    vt[1]  = mkv(32'h22, 8'd5, RUN, 64'hFFFF, 0, np);
    vt[2]  = mkv(32'h33, 8'd5, RUN, 64'hFFFF, 0, np);
    vt[3]  = mkv(32'h44, 8'd5, RUN, 64'hFFFF, 1,
                 mkp(128'h00000044_00000033_00000022_00000011, 64'h1000_0000_0000_00A1,
                     8'd5, RUN, 3'd4));
    vt[4]  = mkv(32'hA, 8'd2, RUN, 64'h2000_0000_0000_00B2, 0, np);
    vt[5]  = mkv(32'hB, 8'd2, RUN, 64'hEEEE, 0, np);
    vt[6]  = mkv(32'hC, 8'd2, DON, 64'hEEEE, 1,
                 mkp(128'h00000000_0000000C_0000000B_0000000A, 64'h2000_0000_0000_00B2,
                     8'd2, DON, 3'd3));
    vt[7]  = mkv(32'hDEAD, 8'd9, BRK, 64'h3000_0000_0000_00C3, 1,
                 mkp('0, 64'h3000_0000_0000_00C3, 8'd9, BRK, 3'd0));
    vt[8]  = mkv(32'h1, 8'd3, RUN, 64'h4000_0000_0000_00D4, 0, np);
    vt[9]  = mkv(32'h2, 8'd3, BRK, 64'hDDDD, 1,
                 mkp(128'h1, 64'h4000_0000_0000_00D4, 8'd3, BRK, 3'd1));
    vt[10] = mkv(32'h99, 8'd4, DON, 64'h5000_0000_0000_00E5, 1,
                 mkp(128'h99, 64'h5000_0000_0000_00E5, 8'd4, DON, 3'd1));
    vt[11] = mkv(32'h5A, 8'd7, INV, 64'h0, 0, np);
    vt[12] = mkv(32'h5B, 8'd7, 4'b0011, 64'h0, 0, np);
    vt[13] = mkv(32'h5C, 8'd7, 4'b0000, 64'h0, 0, np);

    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_outputs("reset");
    ap_rst_n = 1'b1;
    idle(2);

    // Table: back-to-back beats, none may stall.
    for (int i = 0; i < 14; i++) begin
      if (vt[i].has_pkt) exp_q.push_back(vt[i].pkt);
      send(vt[i].data, vt[i].id, vt[i].st, vt[i].meta, s);
      check($sformatf("vec%0d_stall", i), s, 0);
    end
    idle(3);
    check("drop_count", drop_count, 3);
    check("table_drained", exp_q.size(), 0);

    // seq_id change: one stall, partial packet out, new beat starts the next packet.
    send(32'hA1, 8'd1, RUN, 64'h6000_0000_0000_0006, s);
    send(32'hB1, 8'd1, RUN, 64'h0, s);
    exp_q.push_back(mkp(128'h000000B1_000000A1, 64'h6000_0000_0000_0006, 8'd1, RUN, 3'd2));
    send(32'hC2, 8'd2, RUN, 64'h7000_0000_0000_0007, s);
    check("mismatch_stall", s, 1);
    exp_q.push_back(mkp(128'h000000D2_000000C2, 64'h7000_0000_0000_0007, 8'd2, DON, 3'd2));
    send(32'hD2, 8'd2, DON, 64'h0, s);
    check("mismatch_next_stall", s, 0);
    idle(3);
    check("mismatch_drained", exp_q.size(), 0);

    // Output backpressure: hold one packet, fill three, fourth waits for the drain.
    pkt_out_ready = 1'b0;
    exp_q.push_back(mkp(128'h00000104_00000103_00000102_00000101, 64'h8, 8'd8, RUN, 3'd4));
    for (int i = 1; i <= 4; i++) send(32'h100 + i, 8'd8, RUN, (i == 1) ? 64'h8 : 64'h0, s);
    k = 0;
    for (int i = 1; i <= 3; i++) begin
      send(32'h200 + i, 8'd9, RUN, (i == 1) ? 64'h9 : 64'h0, s);
      k += s;
    end
    check("bp_fill_stall", k, 0);
    exp_q.push_back(mkp(128'h00000204_00000203_00000202_00000201, 64'h9, 8'd9, RUN, 3'd4));
    bad = 0;
    fork
      send(32'h204, 8'd9, RUN, 64'h0, s);
      begin
        repeat (3) begin
          @(negedge ap_clk);
          if (resp_in_ready) bad = 1;
        end
        check("bp_ready_low", bad, 0);
        check("bp_hold_valid", pkt_out_valid, 1);
        check("bp_hold_data", pkt_out_data, 128'h00000104_00000103_00000102_00000101);
        @(posedge ap_clk);
        #1;
        pkt_out_ready = 1'b1;
      end
    join
    resp_in_valid = 1'b0;
    check("bp_fourth_stall", s, 3);
    @(negedge ap_clk);
    check("bp_second_valid", pkt_out_valid, 1);
    check("bp_second_count", pkt_out_count, 4);
    idle(3);
    check("bp_drained", exp_q.size(), 0);

    // Reset mid-fill discards the partial packet and the drop counter.
    send(32'hE1, 8'd3, RUN, 64'h0, s);
    send(32'hE2, 8'd3, RUN, 64'h0, s);
    resp_in_valid = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    exp_q.push_back(mkp(128'h000000F4_000000F3_000000F2_000000F1, 64'hF, 8'd4, RUN, 3'd4));
    for (int i = 1; i <= 4; i++) send(32'hF0 + i, 8'd4, RUN, (i == 1) ? 64'hF : 64'h0, s);
    idle(3);
    check("postreset_drained", exp_q.size(), 0);

    // Idle flush after 8 cycles; the FLUSH_TIMEOUT=0 instance must stay silent.
    exp_q.push_back(mkp(128'h77, 64'hA, 8'd6, RUN, 3'd1));
    send(32'h77, 8'd6, RUN, 64'hA, s);
    resp_in_valid = 1'b0;
    k = 0;
    nt_bad = 0;
    do begin
      k++;
      @(negedge ap_clk);
      if (nt_valid) nt_bad = 1;
    end while (!pkt_out_valid && k < 40);
    check("timeout_latency", k, 9);
    repeat (40) begin
      @(negedge ap_clk);
      if (nt_valid) nt_bad = 1;
    end
    check("no_flush_ft0", nt_bad, 0);
    check("timeout_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
